// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-SRAM request/response bus between the fetch controller and SRAM.
interface inst_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (output inst_req, inst_addr,
                  input  inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave  (input  inst_req, inst_addr,
                  output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM request at a time,
// holds the fetched word for decode, handles redirects and misaligned PCs.
module inst_fetch_ctrl (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pc_addr,
  input  logic                    redirect,
  input  logic                    id_allowin,
  inst_fetch_ctrl_if.master       sram,
  output logic                    PC_fresh,
  output logic                    if_valid,
  output logic [31:0]             if_inst,
  output logic [31:0]             if_pc,
  output logic                    if_adel,
  output logic [31:0]             fetch_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_if_inst, r_if_pc, r_fetch_cnt;
  logic        r_if_adel;
  logic        w_aligned, w_req, w_fresh, w_valid;
  logic        w_cap_pc, w_cap_adel, w_cap_data, w_cnt_inc;

  assign w_aligned = (pc_addr[1:0] == 2'b00);

  // Next-state and per-cycle control; redirect always wins, and a response
  // already in flight is drained before anything new is issued.
  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_fresh    = 1'b0;
    w_valid    = 1'b0;
    w_cap_pc   = 1'b0;
    w_cap_adel = 1'b0;
    w_cap_data = 1'b0;
    w_cnt_inc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_next  = S_REQ;
        w_fresh = redirect;
      end
      S_REQ: begin
        w_req = ~redirect & w_aligned;
        if (redirect) begin
          w_fresh = 1'b1;
        end else if (!w_aligned) begin
          w_cap_adel = 1'b1;
          w_next     = S_HOLD;
        end else if (sram.inst_addr_ok) begin
          w_cap_pc = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sram.inst_data_ok) begin
          if (redirect) begin
            w_fresh = 1'b1;
            w_next  = S_REQ;
          end else begin
            w_cap_data = 1'b1;
            w_next     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        w_valid = ~redirect;
        if (redirect) begin
          w_fresh = 1'b1;
          w_next  = S_REQ;
        end else if (id_allowin) begin
          w_fresh   = 1'b1;
          w_cnt_inc = ~r_if_adel;
          w_next    = S_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Reset forces every handshake output quiet, whatever state is held.
    if (rst) begin
      w_req   = 1'b0;
      w_fresh = 1'b0;
      w_valid = 1'b0;
    end
  end

  // State register and held fetch slot / delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_if_inst   <= '0;
      r_if_pc     <= '0;
      r_if_adel   <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap_pc) r_if_pc <= pc_addr;
      if (w_cap_adel) begin
        r_if_adel <= 1'b1;
        r_if_inst <= '0;
        r_if_pc   <= pc_addr;
      end
      if (w_cap_data) begin
        r_if_inst <= sram.inst_rdata;
        r_if_adel <= 1'b0;
      end
      if (w_cnt_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign sram.inst_req  = w_req;
  assign sram.inst_addr = pc_addr;
  assign PC_fresh       = w_fresh;
  assign if_valid       = w_valid;
  assign if_inst        = r_if_inst;
  assign if_pc          = r_if_pc;
  assign if_adel        = r_if_adel & ~rst;
  assign fetch_cnt      = r_fetch_cnt;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl. Inputs change at the falling edge,
// outputs are sampled 1ns later, so each check sees one settled cycle.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        redirect, id_allowin;
  logic        PC_fresh, if_valid, if_adel;
  logic [31:0] if_inst, if_pc, fetch_cnt;
  int          checks = 0;
  int          errors = 0;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .redirect(redirect),
    .id_allowin(id_allowin), .sram(bus), .PC_fresh(PC_fresh),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_adel(if_adel), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_addr = 32'hBFC00000; redirect = 1'b1; id_allowin = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    repeat (3) nxt();
    #1;
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.inst_req); end
    checks++; if (PC_fresh !== 1'b0) begin errors++; $display("FAIL rst_fresh got %b want 0", PC_fresh); end
    checks++; if (if_valid !== 1'b0 || if_adel !== 1'b0) begin errors++; $display("FAIL rst_valid_adel got %b%b want 00", if_valid, if_adel); end
    checks++; if (if_inst !== 32'h0 || if_pc !== 32'h0 || fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_regs got %h %h %h want 0 0 0", if_inst, if_pc, fetch_cnt); end
    redirect = 1'b0;
    nxt(); rst = 1'b0; #1;
    checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", bus.inst_req); end
    nxt(); #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC00000) begin errors++; $display("FAIL first_req got %b %h want 1 bfc00000", bus.inst_req, bus.inst_addr); end
  endtask

  // Starts in REQ for 0xBFC00000; ends in REQ for 0xBFC00004.
  task automatic test_basic_fetch();
    bus.inst_addr_ok = 1'b1;
    nxt(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h24080001; #1;
    checks++; if (bus.inst_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL wait_quiet got %b %b want 0 0", bus.inst_req, if_valid); end
    nxt(); bus.inst_data_ok = 1'b0; id_allowin = 1'b1; #1;
    checks++; if (if_valid !== 1'b1 || PC_fresh !== 1'b1) begin errors++; $display("FAIL hold_valid_fresh got %b %b want 1 1", if_valid, PC_fresh); end
    checks++; if (if_inst !== 32'h24080001 || if_pc !== 32'hBFC00000 || if_adel !== 1'b0) begin errors++; $display("FAIL hold_slot got %h %h %b want 24080001 bfc00000 0", if_inst, if_pc, if_adel); end
    nxt(); id_allowin = 1'b0; pc_addr = 32'hBFC00004; #1;
    checks++; if (fetch_cnt !== 32'd1 || PC_fresh !== 1'b0) begin errors++; $display("FAIL basic_cnt got %h %b want 1 0", fetch_cnt, PC_fresh); end
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC00004) begin errors++; $display("FAIL next_req got %b %h want 1 bfc00004", bus.inst_req, bus.inst_addr); end
  endtask

  task automatic test_stall_hold();
    bus.inst_addr_ok = 1'b1;
    nxt(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h8C090010;
    nxt(); bus.inst_data_ok = 1'b0; id_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (if_valid !== 1'b1 || PC_fresh !== 1'b0 || if_inst !== 32'h8C090010 || if_pc !== 32'hBFC00004) begin
        errors++; $display("FAIL stall_%0d got %b %b %h %h want 1 0 8c090010 bfc00004", i, if_valid, PC_fresh, if_inst, if_pc);
      end
      nxt();
    end
    id_allowin = 1'b1; #1;
    checks++; if (PC_fresh !== 1'b1 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_release got %b %b want 1 1", PC_fresh, if_valid); end
    nxt(); id_allowin = 1'b0; pc_addr = 32'hBFC00008; #1;
    checks++; if (PC_fresh !== 1'b0 || fetch_cnt !== 32'd2 || bus.inst_req !== 1'b1) begin errors++; $display("FAIL stall_after got %b %h %b want 0 2 1", PC_fresh, fetch_cnt, bus.inst_req); end
  endtask

  task automatic test_redirect_wait();
    bus.inst_addr_ok = 1'b1;
    nxt(); bus.inst_addr_ok = 1'b0; redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (PC_fresh !== 1'b0 || bus.inst_req !== 1'b0 || if_valid !== 1'b0) begin
        errors++; $display("FAIL rdw_wait_%0d got %b %b %b want 0 0 0", i, PC_fresh, bus.inst_req, if_valid);
      end
      nxt();
    end
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEADBEEF; #1;
    checks++; if (PC_fresh !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL rdw_drain got %b %b want 1 0", PC_fresh, if_valid); end
    nxt(); bus.inst_data_ok = 1'b0; redirect = 1'b0; pc_addr = 32'hBFC00380; #1;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC00380) begin errors++; $display("FAIL rdw_newreq got %b %h want 1 bfc00380", bus.inst_req, bus.inst_addr); end
    checks++; if (fetch_cnt !== 32'd2 || if_inst !== 32'h8C090010) begin errors++; $display("FAIL rdw_state got %h %h want 2 8c090010", fetch_cnt, if_inst); end
  endtask

  task automatic test_adel();
    bus.inst_addr_ok = 1'b1;
    nxt(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h00001111;
    nxt(); bus.inst_data_ok = 1'b0; id_allowin = 1'b1;
    nxt(); id_allowin = 1'b0; pc_addr = 32'hBFC00002; #1;
    checks++; if (bus.inst_req !== 1'b0 || fetch_cnt !== 32'd3) begin errors++; $display("FAIL adel_noreq got %b %h want 0 3", bus.inst_req, fetch_cnt); end
    nxt(); #1;
    checks++; if (if_valid !== 1'b1 || if_adel !== 1'b1 || bus.inst_req !== 1'b0) begin errors++; $display("FAIL adel_hold got %b %b %b want 1 1 0", if_valid, if_adel, bus.inst_req); end
    checks++; if (if_pc !== 32'hBFC00002 || if_inst !== 32'h0) begin errors++; $display("FAIL adel_slot got %h %h want bfc00002 0", if_pc, if_inst); end
    id_allowin = 1'b1; #1;
    checks++; if (PC_fresh !== 1'b1) begin errors++; $display("FAIL adel_accept got %b want 1", PC_fresh); end
    nxt(); id_allowin = 1'b0; pc_addr = 32'hBFC00010; #1;
    checks++; if (fetch_cnt !== 32'd3 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC00010) begin errors++; $display("FAIL adel_after got %h %b %h want 3 1 bfc00010", fetch_cnt, bus.inst_req, bus.inst_addr); end
  endtask

  task automatic test_redirect_hold();
    bus.inst_addr_ok = 1'b1;
    nxt(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h00002222;
    nxt(); bus.inst_data_ok = 1'b0; redirect = 1'b1; id_allowin = 1'b1; #1;
    checks++; if (if_valid !== 1'b0 || PC_fresh !== 1'b1) begin errors++; $display("FAIL rdh_drop got %b %b want 0 1", if_valid, PC_fresh); end
    nxt(); redirect = 1'b0; id_allowin = 1'b0; pc_addr = 32'hBFC00380; #1;
    checks++; if (fetch_cnt !== 32'd3 || PC_fresh !== 1'b0 || bus.inst_req !== 1'b1) begin errors++; $display("FAIL rdh_after got %h %b %b want 3 0 1", fetch_cnt, PC_fresh, bus.inst_req); end
  endtask

  task automatic test_wrap();
    force dut.r_fetch_cnt = 32'hFFFFFFFE;
    #1 release dut.r_fetch_cnt;
    for (int i = 0; i < 2; i++) begin
      bus.inst_addr_ok = 1'b1;
      nxt(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1000 + i;
      nxt(); bus.inst_data_ok = 1'b0; id_allowin = 1'b1;
      nxt(); id_allowin = 1'b0; pc_addr = pc_addr + 32'd4; #1;
      checks++;
      if (fetch_cnt !== ((i == 0) ? 32'hFFFFFFFF : 32'h0)) begin
        errors++; $display("FAIL wrap_%0d got %h want %h", i, fetch_cnt, (i == 0) ? 32'hFFFFFFFF : 32'h0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_adel();
    test_redirect_hold();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
